// File: rtl/os_ts_monitor.sv
// Training-set monitor: classifies lane-sorted Gen1/Gen2 ordered sets as TS1/TS2/invalid,
// checks link/lane numbering and counts consecutive identical training sets for the LTSSM.
module os_ts_monitor #(
  parameter int unsigned MAX_LANES   = 16,
  parameter int unsigned COUNT_WIDTH = 5,
  parameter logic [7:0]  TS1_ID      = 8'h4A,
  parameter logic [7:0]  TS2_ID      = 8'h45,
  parameter logic [7:0]  PAD         = 8'hF7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               numberOfDetectedLanes,
  input  logic                     osValid,
  input  logic [128*MAX_LANES-1:0] osIn,
  input  logic                     clearCount,
  output logic                     tsValid,
  output logic [1:0]               tsType,
  output logic [COUNT_WIDTH-1:0]   consecutiveCount,
  output logic [7:0]               linkNumber,
  output logic [7:0]               nFts,
  output logic [7:0]               dataRate,
  output logic [7:0]               trainingCtrl,
  output logic                     linkPad,
  output logic                     lanePad,
  output logic                     laneNumberMatch,
  output logic                     laneReversed,
  output logic                     ts1Rx8,
  output logic                     ts2Rx8
);

  typedef enum logic [0:0] {StIdle, StTracking} state_e;

  localparam logic [7:0]             Com      = 8'hBC;
  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  state_e state_q, state_d;

  logic [1:0] prev_type_q;
  logic [7:0] prev_s1_q, prev_s3_q, prev_s4_q, prev_s5_q;

  logic                   n_ok, ts_ok, lane_pad, lane_match, lane_rev, rec_match;
  logic [7:0]             l0_s1, l0_s3, l0_s4, l0_s5, l0_id;
  logic [1:0]             ts_type;
  logic [31:0]            n_lanes;
  logic [127:0]           lane;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   take_os;

  assign n_lanes = 32'(numberOfDetectedLanes);
  assign l0_s1   = osIn[15:8];
  assign l0_s3   = osIn[31:24];
  assign l0_s4   = osIn[39:32];
  assign l0_s5   = osIn[47:40];
  assign l0_id   = osIn[55:48];
  assign take_os = osValid && n_ok && !clearCount;

  always_comb begin
    n_ok       = (numberOfDetectedLanes == 5'd1) || (numberOfDetectedLanes == 5'd2) ||
                 (numberOfDetectedLanes == 5'd4) || (numberOfDetectedLanes == 5'd8) ||
                 (numberOfDetectedLanes == 5'd16);
    ts_ok      = (l0_id == TS1_ID) || (l0_id == TS2_ID);
    lane_pad   = 1'b1;
    lane_match = 1'b1;
    lane_rev   = 1'b1;
    lane       = '0;
    // Every active lane must agree with lane 0 on all symbols except the lane number.
    for (int k = 0; k < MAX_LANES; k++) begin
      if (32'(k) < n_lanes) begin
        lane = osIn[128*k +: 128];
        if (lane[7:0] != Com) ts_ok = 1'b0;
        if (lane[15:8] != l0_s1 || lane[31:24] != l0_s3 ||
            lane[39:32] != l0_s4 || lane[47:40] != l0_s5) ts_ok = 1'b0;
        for (int s = 6; s < 16; s++) begin
          if (lane[8*s +: 8] != l0_id) ts_ok = 1'b0;
        end
        if (lane[23:16] != PAD) lane_pad = 1'b0;
        if (lane[23:16] != 8'(k)) lane_match = 1'b0;
        if (lane[23:16] != 8'(n_lanes - 32'(k) - 32'd1)) lane_rev = 1'b0;
      end
    end
  end

  always_comb begin
    ts_type    = (l0_id == TS1_ID) ? 2'b01 : 2'b10;
    rec_match  = (state_q == StTracking) && (prev_type_q == ts_type) &&
                 (prev_s1_q == l0_s1) && (prev_s3_q == l0_s3) &&
                 (prev_s4_q == l0_s4) && (prev_s5_q == l0_s5);
    count_next = COUNT_WIDTH'(1);
    if (rec_match) begin
      count_next = (consecutiveCount == CountMax) ? CountMax : consecutiveCount + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clearCount) begin
      state_d = StIdle;
    end else if (take_os) begin
      state_d = ts_ok ? StTracking : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tsValid          <= 1'b0;
      tsType           <= 2'b00;
      consecutiveCount <= '0;
      linkNumber       <= 8'h00;
      nFts             <= 8'h00;
      dataRate         <= 8'h00;
      trainingCtrl     <= 8'h00;
      linkPad          <= 1'b0;
      lanePad          <= 1'b0;
      laneNumberMatch  <= 1'b0;
      laneReversed     <= 1'b0;
      prev_type_q      <= 2'b00;
      prev_s1_q        <= 8'h00;
      prev_s3_q        <= 8'h00;
      prev_s4_q        <= 8'h00;
      prev_s5_q        <= 8'h00;
    end else begin
      tsValid <= 1'b0;
      if (clearCount) begin
        consecutiveCount <= '0;
        prev_type_q      <= 2'b00;
      end else if (take_os) begin
        tsValid         <= 1'b1;
        linkNumber      <= l0_s1;
        nFts            <= l0_s3;
        dataRate        <= l0_s4;
        trainingCtrl    <= l0_s5;
        linkPad         <= (l0_s1 == PAD);
        lanePad         <= lane_pad;
        laneNumberMatch <= lane_match;
        laneReversed    <= lane_rev && !lane_match;
        if (ts_ok) begin
          tsType           <= ts_type;
          consecutiveCount <= count_next;
          prev_type_q      <= ts_type;
          prev_s1_q        <= l0_s1;
          prev_s3_q        <= l0_s3;
          prev_s4_q        <= l0_s4;
          prev_s5_q        <= l0_s5;
        end else begin
          tsType           <= 2'b00;
          consecutiveCount <= '0;
          prev_type_q      <= 2'b00;
        end
      end
    end
  end

  assign ts1Rx8 = (tsType == 2'b01) && (consecutiveCount >= COUNT_WIDTH'(8));
  assign ts2Rx8 = (tsType == 2'b10) && (consecutiveCount >= COUNT_WIDTH'(8));

endmodule

// File: tb/tb_os_ts_monitor.sv
// Self-checking bench for os_ts_monitor: directed vector table, hand sequences for
// invalid/saturation/reset corners, and randomized traffic against a behavioural model.
module tb_os_ts_monitor;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    numberOfDetectedLanes;
  logic          osValid;
  logic [2047:0] osIn;
  logic          clearCount;
  logic          tsValid;
  logic [1:0]    tsType;
  logic [4:0]    consecutiveCount;
  logic [7:0]    linkNumber, nFts, dataRate, trainingCtrl;
  logic          linkPad, lanePad, laneNumberMatch, laneReversed, ts1Rx8, ts2Rx8;

  int checks = 0;
  int errors = 0;

  os_ts_monitor dut (
    .clk                  (clk),
    .reset                (reset),
    .numberOfDetectedLanes(numberOfDetectedLanes),
    .osValid              (osValid),
    .osIn                 (osIn),
    .clearCount           (clearCount),
    .tsValid              (tsValid),
    .tsType               (tsType),
    .consecutiveCount     (consecutiveCount),
    .linkNumber           (linkNumber),
    .nFts                 (nFts),
    .dataRate             (dataRate),
    .trainingCtrl         (trainingCtrl),
    .linkPad              (linkPad),
    .lanePad              (lanePad),
    .laneNumberMatch      (laneNumberMatch),
    .laneReversed         (laneReversed),
    .ts1Rx8               (ts1Rx8),
    .ts2Rx8               (ts2Rx8)
  );

  always #5 clk = ~clk;

  // Behavioural model state: visible outputs plus the remembered previous TS.
  bit       m_valid, m_lpad, m_npad, m_match, m_rev;
  int       m_type, m_count;
  bit [7:0] m_link, m_nfts, m_rate, m_ctrl;
  bit       r_valid;
  int       r_type;
  bit [7:0] r_sym[4];

  typedef struct {
    int       n;
    bit [7:0] link;
    int       lmode;
    bit [7:0] id;
    bit [7:0] ctrl;
    bit       clr;
    bit       e_valid;
    int       e_type;
    int       e_count;
    bit       e_rx1;
    bit       e_rx2;
    bit       e_match;
    bit       e_rev;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int n, bit [7:0] link, int lmode, bit [7:0] id, bit [7:0] ctrl,
                             bit clr, bit ev, int et, int ec, bit r1, bit r2, bit em, bit er);
    vec_t x;
    x.n = n; x.link = link; x.lmode = lmode; x.id = id; x.ctrl = ctrl; x.clr = clr;
    x.e_valid = ev; x.e_type = et; x.e_count = ec; x.e_rx1 = r1; x.e_rx2 = r2;
    x.e_match = em; x.e_rev = er;
    return x;
  endfunction

  function automatic logic [7:0] get(input logic [2047:0] os, input int k, input int s);
    return os[128*k + 8*s +: 8];
  endfunction

  // lmode: 0 = lane fields PAD, 1 = lane k reports k, 2 = lane k reports n-1-k.
  function automatic logic [2047:0] make_os(input int n, input logic [7:0] link, input int lmode,
                                            input logic [7:0] id, input logic [7:0] ctrl);
    logic [2047:0] os;
    logic [7:0]    ln;
    for (int k = 0; k < 16; k++) begin
      if (k >= n) begin
        os[128*k +: 128] = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        ln = (lmode == 0) ? 8'hF7 : (lmode == 1) ? 8'(k) : 8'(n - 1 - k);
        os[128*k +: 128] = {{10{id}}, ctrl, 8'h02, 8'h10, ln, link, 8'hBC};
      end
    end
    return os;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_lpad = 0; m_npad = 0; m_match = 0; m_rev = 0;
    m_type = 0; m_count = 0; m_link = 0; m_nfts = 0; m_rate = 0; m_ctrl = 0;
    r_valid = 0; r_type = 0;
    for (int i = 0; i < 4; i++) r_sym[i] = 0;
  endtask

  task automatic model_step(input bit osv, input bit clr, input int n, input logic [2047:0] os);
    bit ok, same;
    int t;
    m_valid = 0;
    if (clr) begin
      m_count = 0;
      r_valid = 0;
      return;
    end
    if (!osv || !(n == 1 || n == 2 || n == 4 || n == 8 || n == 16)) return;
    m_valid = 1;
    m_link  = get(os, 0, 1);
    m_nfts  = get(os, 0, 3);
    m_rate  = get(os, 0, 4);
    m_ctrl  = get(os, 0, 5);
    m_lpad  = (m_link == 8'hF7);
    ok      = (get(os, 0, 6) == 8'h4A) || (get(os, 0, 6) == 8'h45);
    m_npad  = 1; m_match = 1; m_rev = 1;
    for (int k = 0; k < n; k++) begin
      if (get(os, k, 0) != 8'hBC) ok = 0;
      foreach (r_sym[i]) if (get(os, k, (i == 0) ? 1 : i + 2) != get(os, 0, (i == 0) ? 1 : i + 2))
        ok = 0;
      for (int s = 6; s < 16; s++) if (get(os, k, s) != get(os, 0, 6)) ok = 0;
      if (get(os, k, 2) != 8'hF7) m_npad = 0;
      if (int'(get(os, k, 2)) != k) m_match = 0;
      if (int'(get(os, k, 2)) != n - 1 - k) m_rev = 0;
    end
    if (m_match) m_rev = 0;
    if (!ok) begin
      m_type = 0; m_count = 0; r_valid = 0;
    end else begin
      t    = (get(os, 0, 6) == 8'h4A) ? 1 : 2;
      same = r_valid && r_type == t && r_sym[0] == m_link && r_sym[1] == m_nfts &&
             r_sym[2] == m_rate && r_sym[3] == m_ctrl;
      m_count = same ? ((m_count + 1 > 31) ? 31 : m_count + 1) : 1;
      m_type  = t;
      r_valid = 1; r_type = t;
      r_sym[0] = m_link; r_sym[1] = m_nfts; r_sym[2] = m_rate; r_sym[3] = m_ctrl;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    check("tsValid", 32'(tsValid), 32'(m_valid));
    check("tsType", 32'(tsType), 32'(m_type));
    check("count", 32'(consecutiveCount), 32'(m_count));
    check("linkNumber", 32'(linkNumber), 32'(m_link));
    check("nFts", 32'(nFts), 32'(m_nfts));
    check("dataRate", 32'(dataRate), 32'(m_rate));
    check("trainingCtrl", 32'(trainingCtrl), 32'(m_ctrl));
    check("linkPad", 32'(linkPad), 32'(m_lpad));
    check("lanePad", 32'(lanePad), 32'(m_npad));
    check("laneMatch", 32'(laneNumberMatch), 32'(m_match));
    check("laneRev", 32'(laneReversed), 32'(m_rev));
    check("ts1Rx8", 32'(ts1Rx8), 32'(m_type == 1 && m_count >= 8));
    check("ts2Rx8", 32'(ts2Rx8), 32'(m_type == 2 && m_count >= 8));
  endtask

  // Present one cycle of input, sample 1 time unit after the capturing edge.
  task automatic cycle(input bit osv, input bit clr, input int n, input logic [2047:0] os);
    numberOfDetectedLanes = 5'(n);
    osValid = osv; clearCount = clr; osIn = os;
    @(posedge clk); #1;
    osValid = 0; clearCount = 0;
    model_step(osv, clr, n, os);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    compare_all();
  endtask

  initial begin
    logic [2047:0] os;
    int            n, k, s;
    bit [7:0]      ids[2];
    bit [7:0]      links[3];
    int            lanes_pool[8];
    ids = '{8'h4A, 8'h45};
    links = '{8'hF7, 8'h00, 8'h05};
    lanes_pool = '{1, 2, 4, 8, 16, 4, 3, 0};

    reset = 1; osValid = 0; clearCount = 0; numberOfDetectedLanes = 5'd4; osIn = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    for (int i = 1; i <= 8; i++) tbl.push_back(v(4, 8'hF7, 0, 8'h4A, 8'h00, 0, 1, 1, i, i == 8, 0, 0, 0));
    for (int i = 1; i <= 5; i++) tbl.push_back(v(8, 8'h01, 1, 8'h45, 8'h00, 0, 1, 2, i, 0, 0, 1, 0));
    tbl.push_back(v(8, 8'h01, 1, 8'h45, 8'h01, 0, 1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(v(4, 8'h00, 2, 8'h4A, 8'h00, 0, 1, 1, 1, 0, 0, 0, 1));
    for (int i = 1; i <= 6; i++) tbl.push_back(v(4, 8'h00, 1, 8'h4A, 8'h08, 0, 1, 1, i, 0, 0, 1, 0));
    tbl.push_back(v(4, 8'h00, 1, 8'h4A, 8'h08, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(4, 8'h00, 1, 8'h4A, 8'h08, 0, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(3, 8'h00, 1, 8'h4A, 8'h08, 0, 0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 8'h00, 1, 8'h4A, 8'h08, 0, 1, 1, 2, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      cycle(1, tbl[i].clr, tbl[i].n,
            make_os(tbl[i].n, tbl[i].link, tbl[i].lmode, tbl[i].id, tbl[i].ctrl));
      check($sformatf("vec%0d.valid", i), 32'(tsValid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d.type", i), 32'(tsType), 32'(tbl[i].e_type));
      check($sformatf("vec%0d.count", i), 32'(consecutiveCount), 32'(tbl[i].e_count));
      check($sformatf("vec%0d.ts1Rx8", i), 32'(ts1Rx8), 32'(tbl[i].e_rx1));
      check($sformatf("vec%0d.ts2Rx8", i), 32'(ts2Rx8), 32'(tbl[i].e_rx2));
      check($sformatf("vec%0d.match", i), 32'(laneNumberMatch), 32'(tbl[i].e_match));
      check($sformatf("vec%0d.rev", i), 32'(laneReversed), 32'(tbl[i].e_rev));
    end

    // tsValid is a single-cycle strobe
    cycle(0, 0, 1, '0);
    check("strobe_drop", 32'(tsValid), 32'd0);

    // Lane 1 carries a TS2 identifier while lane 0 carries TS1
    os = make_os(2, 8'h00, 1, 8'h4A, 8'h00);
    for (int j = 6; j < 16; j++) os[128 + 8*j +: 8] = 8'h45;
    cycle(1, 0, 2, os);
    check("mixed.type", 32'(tsType), 32'd0);
    check("mixed.count", 32'(consecutiveCount), 32'd0);
    check("mixed.valid", 32'(tsValid), 32'd1);

    // Saturation, then reset mid-stream
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 16, make_os(16, 8'h03, 1, 8'h45, 8'h00));
      check("sat.count", 32'(consecutiveCount), 32'((i + 1 > 31) ? 31 : i + 1));
    end
    check("sat.ts2Rx8", 32'(ts2Rx8), 32'd1);
    do_reset();
    check("rst.count", 32'(consecutiveCount), 32'd0);
    check("rst.type", 32'(tsType), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 16, make_os(16, 8'h03, 1, 8'h45, 8'h00));
      check("post_rst.count", 32'(consecutiveCount), 32'(i));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      n  = lanes_pool[$urandom_range(7)];
      os = make_os(n, links[$urandom_range(2)], $urandom_range(2), ids[$urandom_range(1)],
                   ($urandom_range(3) == 0) ? 8'h01 : 8'h00);
      if ($urandom_range(9) == 0 && n > 0) begin
        k = $urandom_range(n - 1);
        s = $urandom_range(15);
        os[128*k + 8*s +: 8] = os[128*k + 8*s +: 8] ^ 8'h10;
      end
      if ($urandom_range(49) == 0) do_reset();
      cycle($urandom_range(5) != 0, $urandom_range(15) == 0, n, os);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
